// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Receives a serial byte stream (one byte per i_rx_valid cycle) and packs the
// bytes big-endian into SIZE-bit instruction words. Each completed word is
// written into the fetch stage's instruction memory with one single-cycle
// write strobe. Loading ends after the halt word is written, or after the
// last memory location is filled. While a load is running, o_loading holds
// the pipeline in stall/reset.
//
// Ports
//   i_clk               clock, all state changes on the rising edge
//   i_rst               asynchronous active-high reset
//   i_start             start a load at address 0 (accepted in IDLE/DONE only)
//   i_rx_data[7:0]      received byte
//   i_rx_valid          i_rx_data valid this cycle (no backpressure)
//   o_inst_write_enable write strobe to the fetch stage (WRITE state only)
//   o_write_addr        word address of the write
//   o_write_data        assembled instruction word
//   o_loading           load in progress (RECV or WRITE)
//   o_done              level, set once the last word is written
//   o_word_count        words written in the current or last load
// -----------------------------------------------------------------------------
module instruction_loader #(
   parameter int              SIZE            = 32,
   parameter int              MAX_INSTRUCTION = 64,
   parameter logic [SIZE-1:0] HALT_WORD       = {SIZE{1'b1}},
   localparam int             ADDR_WIDTH      = $clog2(MAX_INSTRUCTION)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_inst_write_enable,
   output logic [ADDR_WIDTH-1:0] o_write_addr,
   output logic [SIZE-1:0]       o_write_data,
   output logic                  o_loading,
   output logic                  o_done,
   output logic [ADDR_WIDTH:0]   o_word_count
);

   localparam int BYTES = SIZE / 8;
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RECV  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(BYTES - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MAX_INSTRUCTION - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

   logic [1:0]            state_reg;
   logic [CNT_W-1:0]      byte_cnt_reg;
   logic [SIZE-1:0]       shreg_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [SIZE-1:0]       data_reg;
   logic                  we_reg;
   logic                  loading_reg;
   logic                  done_reg;
   logic [ADDR_WIDTH:0]   count_reg;

   // New byte enters at the bottom; after BYTES shifts the first byte
   // received sits in the most significant position.
   logic [SIZE+7:0] shift_cat;
   logic [SIZE-1:0] shift_next;
   logic            last_byte;
   logic            last_word;

   assign shift_cat  = {shreg_reg, i_rx_data};
   assign shift_next = shift_cat[SIZE-1:0];
   assign last_byte  = (byte_cnt_reg == CNT_LAST);
   // Evaluated during WRITE, where data_reg/addr_reg hold the word being written.
   assign last_word  = (data_reg == HALT_WORD) || (addr_reg == ADDR_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg    <= ST_IDLE;
         byte_cnt_reg <= '0;
         shreg_reg    <= '0;
         addr_reg     <= '0;
         data_reg     <= '0;
         we_reg       <= 1'b0;
         loading_reg  <= 1'b0;
         done_reg     <= 1'b0;
         count_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               // Bytes arriving here are ignored, including one that
               // coincides with i_start.
               if (i_start) begin
                  state_reg    <= ST_RECV;
                  byte_cnt_reg <= '0;
                  shreg_reg    <= '0;
                  addr_reg     <= '0;
                  count_reg    <= '0;
                  done_reg     <= 1'b0;
                  loading_reg  <= 1'b1;
               end
            end

            ST_RECV: begin
               if (i_rx_valid) begin
                  shreg_reg <= shift_next;
                  if (last_byte) begin
                     // Word complete: present it on the registered write
                     // port for exactly the next cycle.
                     state_reg    <= ST_WRITE;
                     byte_cnt_reg <= '0;
                     data_reg     <= shift_next;
                     we_reg       <= 1'b1;
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg + CNT_ONE;
                  end
               end
            end

            ST_WRITE: begin
               we_reg    <= 1'b0;
               count_reg <= count_reg + COUNT_ONE;
               if (last_word) begin
                  state_reg   <= ST_DONE;
                  loading_reg <= 1'b0;
                  done_reg    <= 1'b1;
               end else begin
                  state_reg <= ST_RECV;
                  addr_reg  <= addr_reg + ADDR_ONE;
                  // A byte arriving in the write cycle is byte 0 of the next
                  // word, so full-rate streams lose nothing.
                  if (i_rx_valid) begin
                     shreg_reg    <= SIZE'(i_rx_data);
                     byte_cnt_reg <= CNT_ONE;
                  end else begin
                     shreg_reg    <= '0;
                     byte_cnt_reg <= '0;
                  end
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_inst_write_enable = we_reg;
   assign o_write_addr        = addr_reg;
   assign o_write_data        = data_reg;
   assign o_loading           = loading_reg;
   assign o_done              = done_reg;
   assign o_word_count        = count_reg;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writes a program into the instruction memory of the fetch stage. Takes a serial byte stream (one byte per `i_rx_valid` pulse, normally from the UART receiver) and packs the bytes into `SIZE`-bit instruction words. It then drives the fetch stage's write port (`i_inst_write_enable`, `i_write_addr`, `i_write_data`) with one single-cycle write per word. While loading, it holds the pipeline through `o_loading`.

## Interface
- `SIZE`, 32: instruction word width; must be a multiple of 8. BYTES = SIZE/8.
- `MAX_INSTRUCTION`, 64: instruction memory depth in words. ADDR_WIDTH = $clog2(MAX_INSTRUCTION).
- `HALT_WORD`, 32'hFFFFFFFF: end-of-program marker word. It is written to memory, then loading stops.
- `i_clk`  input  1  clock. All state changes on the rising edge.
- `i_rst`  input  1  reset. Asynchronous, active-high.
- `i_start`  input  1  begin a load at address 0. Sampled only in IDLE or DONE.
- `i_rx_data`  input  8  received byte.
- `i_rx_valid`  input  1  `i_rx_data` is valid this cycle. One byte per high cycle; no backpressure.
- `o_inst_write_enable`  output  1  write strobe. Connects to the fetch stage's `i_inst_write_enable`.
- `o_write_addr`  output  ADDR_WIDTH  word address. Connects to `i_write_addr`.
- `o_write_data`  output  SIZE  assembled word. Connects to `i_write_data`.
- `o_loading`  output  1  load in progress. Drives stall and reset-hold of the pipeline.
- `o_done`  output  1  level. Set when the last word has been written; cleared by `i_start` or reset.
- `o_word_count`  output  ADDR_WIDTH+1  number of words written in the current or last load.

## Operation
- **States**
  - IDLE: after reset.
  - RECV: collecting bytes.
  - WRITE: one-cycle memory write.
  - DONE: load complete.
- **IDLE/DONE**
  - If `i_start`=1: go to RECV. Clear byte counter, word address, `o_word_count`, `o_done` and shift register.
  - Bytes arriving in IDLE/DONE are ignored.
- **RECV**
  - Each `i_rx_valid` cycle: shift register becomes {shreg[SIZE-9:0], i_rx_data}, so the word is sent MSB first (big-endian).
  - The byte counter increments, running 0..BYTES-1.
  - On the BYTES-th byte: go to WRITE and clear the byte counter.
  - `i_start` is ignored.
- **WRITE** (exactly 1 cycle)
  - `o_inst_write_enable`=1, `o_write_addr`=current word address, `o_write_data`=assembled word.
  - Next state:
    - DONE if the word equals `HALT_WORD`, or the address equals MAX_INSTRUCTION-1. `o_word_count` increments and `o_done` is set.
    - Otherwise RECV. The address increments and `o_word_count` increments.
  - If `i_rx_valid`=1 during WRITE and the next state is RECV, that byte is taken as byte 0 of the next word and the byte counter becomes 1. When the next state is DONE, the byte is dropped.
- **Outputs**
  - `o_write_data` and `o_write_addr` are registered and stable for the whole WRITE cycle.
  - `o_inst_write_enable` is 0 in every state except WRITE.
- **Reset values**
  - State IDLE.
  - `o_inst_write_enable`=0, `o_write_addr`=0, `o_write_data`=0.
  - `o_loading`=0, `o_done`=0, `o_word_count`=0.
  - Byte counter and shift register = 0.
- **Reset mid-load**: the load is abandoned immediately and all outputs return to their reset values asynchronously. Words already written stay in memory. No partial word is written.

## Timing
- Latency:
  - `i_start` at cycle n: RECV and `o_loading`=1 from n+1.
  - Last byte of a word accepted at cycle m: write strobe high in cycle m+1 only. The fetch stage captures the write on the falling edge of m+1.
- `o_loading`:
  - =1 in RECV and WRITE, including the WRITE cycle of the final word.
  - =0 from the cycle DONE is entered.
- `o_done` rises in the same cycle `o_loading` falls.
- Maximum throughput is one byte per cycle, including bytes arriving in the WRITE cycle: BYTES cycles per word, with no bytes lost.
- When `i_start` and `i_rx_valid` occur together in IDLE, the byte is ignored.

## Test plan
- **Reset:** hold `i_rst`, then release.
  - Expect all outputs 0, state IDLE.
  - Bytes 0x12, 0x34 with no `i_start` produce no write strobe.
- **Basic load:** `i_start`, then bytes 20 08 00 05, 00 00 00 00, FF FF FF FF.
  - Expect strobes: addr 0 data 32'h20080005, addr 1 data 0, addr 2 data 32'hFFFFFFFF.
  - Then `o_done`=1, `o_loading`=0, `o_word_count`=3.
- **Back-to-back bytes:** 8 consecutive `i_rx_valid` cycles (11 22 33 44 55 66 77 88), with byte 0x55 arriving in the WRITE cycle.
  - Expect words 32'h11223344 at addr 0 and 32'h55667788 at addr 1.
- **Capacity cutoff:** MAX_INSTRUCTION=4, stream 5 non-halt words.
  - Expect 4 strobes at addr 0..3, then DONE with `o_word_count`=4.
  - 5th word's bytes cause no strobe.
- **Reset mid-load:** assert `i_rst` asynchronously after 2 bytes of word 1.
  - Expect `o_loading`, `o_write_addr` and `o_inst_write_enable` at 0 before the next edge.
  - No strobe for the partial word.
- **Restart:** after DONE, bytes alone produce no strobe. `i_start` restarts the load.
  - Expect `o_done`=0 and the next strobe at addr 0.
  - `i_start` pulsed mid-RECV has no effect.
